hsv_to_rgb: RTL and testbench
=============================

Name: hsv_to_rgb

Overview:
- Pipelined HSV-to-RGB converter; the inverse of the camera path's RGB-to-HSV stage.
- Regenerates display pixels after hue/saturation/value processing, such as colour masking or highlight overlay.
- Produces RGB888 plus an RGB444 copy for the VGA DAC.
- Carries an aligned sideband bus, for example sync bits or a pixel tag.

Parameters:
- SB_W, 4, width of the sideband bus delayed alongside the pixel data.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  pipeline advance; when low all stages hold.
- valid_in  in  1  input pixel valid.
- h_in  in  9  hue in degrees, nominal 0-359.
- s_in  in  8  saturation, 0-255.
- v_in  in  8  value, 0-255.
- sb_in  in  SB_W  sideband, delayed with the pixel.
- r_out, g_out, b_out  out  8 each  RGB888 result.
- r4_out, g4_out, b4_out  out  4 each  bits [7:4] of the matching 8-bit output, combinational from the output registers.
- sb_out  out  SB_W  delayed sideband.
- valid_out  out  1  output valid.

Behaviour:
- Reset (synchronous, active-high, one clk edge):
  - Every stage valid and data register is cleared.
  - r/g/b_out = 0, sb_out = 0, valid_out = 0.
  - reset has priority over en.
  - Reset mid-stream discards all in-flight pixels; no valid_out appears until new input has travelled 4 stages.
- Latency and advance:
  - Fixed latency of 4 en-qualified cycles, input to output registers.
  - With en=1 each cycle: sample at edge N gives output after edge N+4.
  - en=0 freezes every register, including the outputs and valid_out, with no bubble and no loss.
- Valid propagation:
  - valid travels with its data.
  - Stages holding invalid data still compute; their outputs are don't-care for data but valid must be 0.
  - Sideband travels through the same 4 registers.
- Stage 1:
  - Hue wrap: if h_in ≥ 360 then h = h_in − 360, else h = h_in.
  - sector = floor(h/60), range 0-5, computed by comparison ladder; f = h − 60·sector, range 0-59.
  - s' = s_in + s_in[7], 9 bits, so 255 maps to 256 and 0 stays 0.
  - Register v, sector, f, s'.
- Stage 2:
  - fr = (f·273)>>6, 8 bits, range 0-251.
  - a_p = s'; a_q = (s'·fr)>>8; a_t = (s'·(256−fr))>>8; each 9 bits, ≤ 256.
- Stage 3:
  - p = (v·(256−a_p))>>8; q = (v·(256−a_q))>>8; t = (v·(256−a_t))>>8.
  - Products are 17 bits; results fit in 8 bits and are ≤ v.
- Stage 4, select by sector as (R,G,B):
  - 0: (v,t,p)
  - 1: (q,v,p)
  - 2: (p,v,t)
  - 3: (p,q,v)
  - 4: (t,p,v)
  - 5: (v,p,q)
- Boundaries:
  - s=0 gives R=G=B=v for any hue.
  - v=0 gives all zero.
  - h=359 falls in sector 5 with f=59.
  - All arithmetic is unsigned; no intermediate may truncate before the >>8.

Decomposition:
- Shared package hsv_pkg holds:
  - constants HUE_MAX=360, SECTOR_DEG=60, FR_MUL=273, FR_SHIFT=6;
  - typedef hsv_t {h[8:0], s[7:0], v[7:0]};
  - typedef rgb_t {r, g, b each [7:0]};
  - an enum for sector 0-5.
- One sub-module, hsv_sector_decode: combinational wrap, sector and f calculation used in stage 1.

Test Plan:
- h=0, s=255, v=255 → (255,0,0), RGB444 (15,0,0), valid_out exactly 4 cycles after valid_in.
- h=120 → (0,255,0); h=240 → (0,0,255); h=60 → (255,255,0); all with s=255, v=255.
- h=30, s=255, v=255 → (255,126,0); h=400, s=255, v=255 wraps to 40 → (255,169,0).
- s=0, v=200, hue sweep over 0/90/359 → (200,200,200) each; v=0 → (0,0,0).
- Back-to-back stream of 8 pixels with en low for 3 cycles mid-stream:
  - outputs and valid_out hold during the low cycles;
  - order and sideband tags preserved, no loss and no duplication.
- Assert reset while 3 valid pixels are in flight:
  - next cycle valid_out=0 and rgb=0;
  - no stale pixel emerges;
  - a new pixel after reset appears 4 cycles later.

Source files
------------

// File: rtl/hsv_pkg.sv
// Shared types and constants for the HSV-to-RGB display path.
package hsv_pkg;

    localparam int HUE_MAX    = 360;
    localparam int SECTOR_DEG = 60;
    localparam int FR_MUL     = 273;
    localparam int FR_SHIFT   = 6;

    typedef struct packed {
        logic [8:0] h;
        logic [7:0] s;
        logic [7:0] v;
    } hsv_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [2:0] {
        SEC_0 = 3'd0,
        SEC_1 = 3'd1,
        SEC_2 = 3'd2,
        SEC_3 = 3'd3,
        SEC_4 = 3'd4,
        SEC_5 = 3'd5
    } sector_e;

endpackage

// File: rtl/hsv_sector_decode.sv
// Hue wrap, 60-degree sector index and offset within the sector.
module hsv_sector_decode
    import hsv_pkg::*;
(
    input  logic [8:0] h_in,
    output sector_e    sector,
    output logic [5:0] f
);

    logic [8:0] h_w;
    logic [8:0] base;

    always_comb begin
        h_w    = (h_in >= 9'(HUE_MAX)) ? h_in - 9'(HUE_MAX) : h_in;
        sector = SEC_0;
        base   = '0;
        // A compare ladder avoids a divider; h_w is at most 359 after one wrap.
        if (h_w >= 9'(5 * SECTOR_DEG)) begin
            sector = SEC_5;
            base   = 9'(5 * SECTOR_DEG);
        end else if (h_w >= 9'(4 * SECTOR_DEG)) begin
            sector = SEC_4;
            base   = 9'(4 * SECTOR_DEG);
        end else if (h_w >= 9'(3 * SECTOR_DEG)) begin
            sector = SEC_3;
            base   = 9'(3 * SECTOR_DEG);
        end else if (h_w >= 9'(2 * SECTOR_DEG)) begin
            sector = SEC_2;
            base   = 9'(2 * SECTOR_DEG);
        end else if (h_w >= 9'(SECTOR_DEG)) begin
            sector = SEC_1;
            base   = 9'(SECTOR_DEG);
        end
        f = 6'(h_w - base);
    end

endmodule

// File: rtl/hsv_to_rgb.sv
// Four-stage HSV-to-RGB converter with an aligned sideband bus and RGB444 taps.
module hsv_to_rgb
    import hsv_pkg::*;
#(
    parameter int SB_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            valid_in,
    input  logic [8:0]      h_in,
    input  logic [7:0]      s_in,
    input  logic [7:0]      v_in,
    input  logic [SB_W-1:0] sb_in,
    output logic [7:0]      r_out,
    output logic [7:0]      g_out,
    output logic [7:0]      b_out,
    output logic [3:0]      r4_out,
    output logic [3:0]      g4_out,
    output logic [3:0]      b4_out,
    output logic [SB_W-1:0] sb_out,
    output logic            valid_out
);

    hsv_t pix_in;
    assign pix_in = '{h: h_in, s: s_in, v: v_in};

    sector_e    dec_sector;
    logic [5:0] dec_f;

    hsv_sector_decode u_decode (
        .h_in   (pix_in.h),
        .sector (dec_sector),
        .f      (dec_f)
    );

    logic            s1_valid_q, s1_valid_d;
    logic [SB_W-1:0] s1_sb_q, s1_sb_d;
    logic [7:0]      s1_v_q, s1_v_d;
    sector_e         s1_sector_q, s1_sector_d;
    logic [5:0]      s1_f_q, s1_f_d;
    logic [8:0]      s1_sp_q, s1_sp_d;

    logic            s2_valid_q, s2_valid_d;
    logic [SB_W-1:0] s2_sb_q, s2_sb_d;
    logic [7:0]      s2_v_q, s2_v_d;
    sector_e         s2_sector_q, s2_sector_d;
    logic [8:0]      s2_ap_q, s2_ap_d;
    logic [8:0]      s2_aq_q, s2_aq_d;
    logic [8:0]      s2_at_q, s2_at_d;

    logic            s3_valid_q, s3_valid_d;
    logic [SB_W-1:0] s3_sb_q, s3_sb_d;
    logic [7:0]      s3_v_q, s3_v_d;
    sector_e         s3_sector_q, s3_sector_d;
    logic [7:0]      s3_p_q, s3_p_d;
    logic [7:0]      s3_q_q, s3_q_d;
    logic [7:0]      s3_t_q, s3_t_d;

    logic            out_valid_q, out_valid_d;
    logic [SB_W-1:0] out_sb_q, out_sb_d;
    rgb_t            out_rgb_q, out_rgb_d;

    // Products are kept at full width; only the final >>8 narrows them.
    logic [13:0] fr_prod;
    logic [7:0]  fr;
    logic [16:0] aq_prod;
    logic [17:0] at_prod;
    logic [16:0] p_prod, q_prod, t_prod;
    rgb_t        rgb_sel;

    assign fr_prod = 14'(s1_f_q) * 14'(FR_MUL);
    assign fr      = 8'(fr_prod >> FR_SHIFT);
    assign aq_prod = 17'(s1_sp_q) * 17'(fr);
    assign at_prod = 18'(s1_sp_q) * 18'(9'd256 - 9'(fr));
    assign p_prod  = 17'(s2_v_q) * 17'(9'd256 - s2_ap_q);
    assign q_prod  = 17'(s2_v_q) * 17'(9'd256 - s2_aq_q);
    assign t_prod  = 17'(s2_v_q) * 17'(9'd256 - s2_at_q);

    always_comb begin
        rgb_sel = '{r: s3_v_q, g: s3_p_q, b: s3_q_q};
        case (s3_sector_q)
            SEC_0:   rgb_sel = '{r: s3_v_q, g: s3_t_q, b: s3_p_q};
            SEC_1:   rgb_sel = '{r: s3_q_q, g: s3_v_q, b: s3_p_q};
            SEC_2:   rgb_sel = '{r: s3_p_q, g: s3_v_q, b: s3_t_q};
            SEC_3:   rgb_sel = '{r: s3_p_q, g: s3_q_q, b: s3_v_q};
            SEC_4:   rgb_sel = '{r: s3_t_q, g: s3_p_q, b: s3_v_q};
            default: rgb_sel = '{r: s3_v_q, g: s3_p_q, b: s3_q_q};
        endcase
    end

    always_comb begin
        // NOTE: every _d first takes its _q so no path infers a latch and en=0 simply holds.
        s1_valid_d  = s1_valid_q;
        s1_sb_d     = s1_sb_q;
        s1_v_d      = s1_v_q;
        s1_sector_d = s1_sector_q;
        s1_f_d      = s1_f_q;
        s1_sp_d     = s1_sp_q;
        s2_valid_d  = s2_valid_q;
        s2_sb_d     = s2_sb_q;
        s2_v_d      = s2_v_q;
        s2_sector_d = s2_sector_q;
        s2_ap_d     = s2_ap_q;
        s2_aq_d     = s2_aq_q;
        s2_at_d     = s2_at_q;
        s3_valid_d  = s3_valid_q;
        s3_sb_d     = s3_sb_q;
        s3_v_d      = s3_v_q;
        s3_sector_d = s3_sector_q;
        s3_p_d      = s3_p_q;
        s3_q_d      = s3_q_q;
        s3_t_d      = s3_t_q;
        out_valid_d = out_valid_q;
        out_sb_d    = out_sb_q;
        out_rgb_d   = out_rgb_q;
        if (en) begin
            s1_valid_d  = valid_in;
            s1_sb_d     = sb_in;
            s1_v_d      = pix_in.v;
            s1_sector_d = dec_sector;
            s1_f_d      = dec_f;
            // Saturation 255 becomes 256 so full saturation drives p to exactly zero.
            s1_sp_d     = {1'b0, pix_in.s} + 9'(pix_in.s[7]);

            s2_valid_d  = s1_valid_q;
            s2_sb_d     = s1_sb_q;
            s2_v_d      = s1_v_q;
            s2_sector_d = s1_sector_q;
            s2_ap_d     = s1_sp_q;
            s2_aq_d     = 9'(aq_prod >> 8);
            s2_at_d     = 9'(at_prod >> 8);

            s3_valid_d  = s2_valid_q;
            s3_sb_d     = s2_sb_q;
            s3_v_d      = s2_v_q;
            s3_sector_d = s2_sector_q;
            s3_p_d      = 8'(p_prod >> 8);
            s3_q_d      = 8'(q_prod >> 8);
            s3_t_d      = 8'(t_prod >> 8);

            out_valid_d = s3_valid_q;
            out_sb_d    = s3_sb_q;
            out_rgb_d   = rgb_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sb_q     <= '0;
            s1_v_q      <= '0;
            s1_sector_q <= SEC_0;
            s1_f_q      <= '0;
            s1_sp_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_sb_q     <= '0;
            s2_v_q      <= '0;
            s2_sector_q <= SEC_0;
            s2_ap_q     <= '0;
            s2_aq_q     <= '0;
            s2_at_q     <= '0;
            s3_valid_q  <= 1'b0;
            s3_sb_q     <= '0;
            s3_v_q      <= '0;
            s3_sector_q <= SEC_0;
            s3_p_q      <= '0;
            s3_q_q      <= '0;
            s3_t_q      <= '0;
            out_valid_q <= 1'b0;
            out_sb_q    <= '0;
            out_rgb_q   <= '0;
        end else begin
            // NOTE: non-blocking updates let every stage read its predecessor's pre-edge value.
            s1_valid_q  <= s1_valid_d;
            s1_sb_q     <= s1_sb_d;
            s1_v_q      <= s1_v_d;
            s1_sector_q <= s1_sector_d;
            s1_f_q      <= s1_f_d;
            s1_sp_q     <= s1_sp_d;
            s2_valid_q  <= s2_valid_d;
            s2_sb_q     <= s2_sb_d;
            s2_v_q      <= s2_v_d;
            s2_sector_q <= s2_sector_d;
            s2_ap_q     <= s2_ap_d;
            s2_aq_q     <= s2_aq_d;
            s2_at_q     <= s2_at_d;
            s3_valid_q  <= s3_valid_d;
            s3_sb_q     <= s3_sb_d;
            s3_v_q      <= s3_v_d;
            s3_sector_q <= s3_sector_d;
            s3_p_q      <= s3_p_d;
            s3_q_q      <= s3_q_d;
            s3_t_q      <= s3_t_d;
            out_valid_q <= out_valid_d;
            out_sb_q    <= out_sb_d;
            out_rgb_q   <= out_rgb_d;
        end
    end

    assign r_out     = out_rgb_q.r;
    assign g_out     = out_rgb_q.g;
    assign b_out     = out_rgb_q.b;
    assign r4_out    = out_rgb_q.r[7:4];
    assign g4_out    = out_rgb_q.g[7:4];
    assign b4_out    = out_rgb_q.b[7:4];
    assign sb_out    = out_sb_q;
    assign valid_out = out_valid_q;

endmodule

// File: tb/tb_hsv_to_rgb.sv
// Scoreboard bench for hsv_to_rgb: directed colours, stalls, mid-stream reset, random traffic.
module tb_hsv_to_rgb;
    import hsv_pkg::*;

    localparam int SB_W = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic            valid_in;
    logic [8:0]      h_in;
    logic [7:0]      s_in;
    logic [7:0]      v_in;
    logic [SB_W-1:0] sb_in;
    logic [7:0]      r_out, g_out, b_out;
    logic [3:0]      r4_out, g4_out, b4_out;
    logic [SB_W-1:0] sb_out;
    logic            valid_out;

    always #5 clk = ~clk;

    hsv_to_rgb #(.SB_W(SB_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .valid_in  (valid_in),
        .h_in      (h_in),
        .s_in      (s_in),
        .v_in      (v_in),
        .sb_in     (sb_in),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out),
        .r4_out    (r4_out),
        .g4_out    (g4_out),
        .b4_out    (b4_out),
        .sb_out    (sb_out),
        .valid_out (valid_out)
    );

    typedef struct {
        rgb_t            rgb;
        logic [SB_W-1:0] sb;
        int              due;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   adv = 0;
    logic fresh = 1'b0;
    logic rst_edge = 1'b0;
    logic hold_valid = 1'b0;
    exp_t last_exp;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: spec arithmetic in plain integers, sector by division.
    function automatic rgb_t model(input int h, input int s, input int v);
        int   hh, sec, f, sp, fr, aq, at, p, q, t;
        rgb_t o;
        hh  = (h >= 360) ? h - 360 : h;
        sec = hh / 60;
        f   = hh % 60;
        sp  = s + ((s >= 128) ? 1 : 0);
        fr  = (f * 273) / 64;
        aq  = (sp * fr) / 256;
        at  = (sp * (256 - fr)) / 256;
        p   = (v * (256 - sp)) / 256;
        q   = (v * (256 - aq)) / 256;
        t   = (v * (256 - at)) / 256;
        case (sec)
            0:       begin o.r = 8'(v); o.g = 8'(t); o.b = 8'(p); end
            1:       begin o.r = 8'(q); o.g = 8'(v); o.b = 8'(p); end
            2:       begin o.r = 8'(p); o.g = 8'(v); o.b = 8'(t); end
            3:       begin o.r = 8'(p); o.g = 8'(q); o.b = 8'(v); end
            4:       begin o.r = 8'(t); o.g = 8'(p); o.b = 8'(v); end
            default: begin o.r = 8'(v); o.g = 8'(p); o.b = 8'(q); end
        endcase
        return o;
    endfunction

    always @(posedge clk) begin
        fresh    <= en && !reset;
        rst_edge <= reset;
        if (en && !reset) adv <= adv + 1;
    end

    // Monitor: compares only on edges that actually advanced the pipeline.
    always @(negedge clk) begin
        if (rst_edge) begin
            check("reset_valid", 32'(valid_out), 32'd0);
            check("reset_rgb", 32'({r_out, g_out, b_out}), 32'd0);
            check("reset_sb", 32'(sb_out), 32'd0);
            hold_valid = 1'b0;
        end else if (fresh) begin
            while (sb_q.size() > 0 && sb_q[0].due < adv) begin
                check("lost_pixel", 32'(sb_q[0].due), 32'(adv));
                void'(sb_q.pop_front());
            end
            hold_valid = (sb_q.size() > 0) && (sb_q[0].due == adv);
            check("valid_out", 32'(valid_out), 32'(hold_valid));
            if (hold_valid) begin
                mon_e = sb_q.pop_front();
                check("rgb888", 32'({r_out, g_out, b_out}), 32'(mon_e.rgb));
                check("rgb444", 32'({r4_out, g4_out, b4_out}),
                      32'({mon_e.rgb.r[7:4], mon_e.rgb.g[7:4], mon_e.rgb.b[7:4]}));
                check("sideband", 32'(sb_out), 32'(mon_e.sb));
                last_exp = mon_e;
            end
        end else begin
            check("hold_valid", 32'(valid_out), 32'(hold_valid));
            if (hold_valid) begin
                check("hold_rgb", 32'({r_out, g_out, b_out}), 32'(last_exp.rgb));
                check("hold_sb", 32'(sb_out), 32'(last_exp.sb));
            end
        end
    end

    task automatic drive(input logic e, input logic vld, input logic [8:0] h, input logic [7:0] s,
                         input logic [7:0] v, input logic [SB_W-1:0] tag, input rgb_t want);
        exp_t x;
        en       = e;
        valid_in = vld;
        h_in     = h;
        s_in     = s;
        v_in     = v;
        sb_in    = tag;
        if (e && vld) begin
            x.rgb = want;
            x.sb  = tag;
            x.due = adv + 4;
            sb_q.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_dir(input logic [8:0] h, input logic [7:0] s, input logic [7:0] v,
                            input logic [SB_W-1:0] tag, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
        rgb_t w;
        w.r = r;
        w.g = g;
        w.b = b;
        drive(1'b1, 1'b1, h, s, v, tag, w);
    endtask

    task automatic send_model(input logic [8:0] h, input logic [7:0] s, input logic [7:0] v,
                              input logic [SB_W-1:0] tag);
        drive(1'b1, 1'b1, h, s, v, tag, model(int'(h), int'(s), int'(v)));
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 9'd0, 8'd0, 8'd0, '0, '0);
    endtask

    task automatic stall();
        drive(1'b0, 1'b1, 9'($urandom_range(0, 511)), 8'($urandom), 8'($urandom), SB_W'($urandom), '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            idle();
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        reset    = 1'b1;
        en       = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        sb_q.delete();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with en low and junk valid input: reset must still win.
        reset    = 1'b1;
        en       = 1'b0;
        valid_in = 1'b1;
        h_in     = 9'd100;
        s_in     = 8'd77;
        v_in     = 8'd99;
        sb_in    = 4'hA;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        en       = 1'b1;
        valid_in = 1'b0;

        // Isolated first pixel: latency is visible as valid_out exactly 4 edges later.
        send_dir(9'd0, 8'd255, 8'd255, 4'h1, 8'd255, 8'd0, 8'd0);
        drain();

        send_dir(9'd120, 8'd255, 8'd255, 4'h2, 8'd0, 8'd255, 8'd0);
        send_dir(9'd240, 8'd255, 8'd255, 4'h3, 8'd0, 8'd0, 8'd255);
        send_dir(9'd60,  8'd255, 8'd255, 4'h4, 8'd255, 8'd255, 8'd0);
        send_dir(9'd30,  8'd255, 8'd255, 4'h5, 8'd255, 8'd126, 8'd0);
        send_dir(9'd400, 8'd255, 8'd255, 4'h6, 8'd255, 8'd169, 8'd0);
        send_dir(9'd0,   8'd0,   8'd200, 4'h7, 8'd200, 8'd200, 8'd200);
        send_dir(9'd90,  8'd0,   8'd200, 4'h8, 8'd200, 8'd200, 8'd200);
        send_dir(9'd359, 8'd0,   8'd200, 4'h9, 8'd200, 8'd200, 8'd200);
        send_dir(9'd200, 8'd255, 8'd0,   4'hA, 8'd0, 8'd0, 8'd0);
        send_dir(9'd359, 8'd255, 8'd255, 4'hB, 8'd255, 8'd0, 8'd4);
        drain();

        // Eight back-to-back pixels with a three-cycle en-low hole after the fourth.
        for (int i = 0; i < 8; i++) begin
            send_model(9'($urandom_range(0, 359)), 8'($urandom), 8'($urandom), SB_W'(i));
            if (i == 3) begin
                repeat (3) stall();
            end
        end
        drain();

        // Reset with three pixels in flight; none of them may emerge.
        for (int i = 0; i < 3; i++) begin
            send_model(9'($urandom_range(0, 359)), 8'd255, 8'd255, SB_W'(12 + i));
        end
        pulse_reset();
        repeat (6) idle();
        send_dir(9'd120, 8'd255, 8'd255, 4'hE, 8'd0, 8'd255, 8'd0);
        drain();

        // Random traffic with random valid gaps and en stalls.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                stall();
            end else if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                send_model(9'($urandom_range(0, 511)), 8'($urandom), 8'($urandom), SB_W'(i));
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
